alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Second-generation CPU ALU: registered, handshaked, parametrised in width.
- Keeps the four existing functional units (arithmetic, logic, left shift, right shift) and adds an iterative shift-add multiplier.
- Holds the status flags in an internal register, so ADC/SBB take carry from the previous result instead of an external carry input.
- Sits between the operand-fetch stage and writeback, one operation in flight at a time.

Parameters:
- bit_width, 8, operand/result width; power of two, >= 4.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  ALU can accept this cycle.
- IN_UNIT  in  3  0 arith, 1 logic, 2 lshift, 3 rshift, 4 mul, 5-7 illegal.
- IN_OP  in  2  sub-operation within the unit.
- IN_A  in  bit_width  operand A.
- IN_B  in  bit_width  operand B; for shifts, only B[$clog2(bit_width)-1:0] is used.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer takes the result.
- OUT_R  out  bit_width  result register.
- OUT_FLAGS  out  4  flag register {SF, ZF, OF, CF}.

Behaviour:
- Reset (synchronous): OUT_VALID=0, OUT_R=0, OUT_FLAGS=0, multiplier idle. IN_READY=0 while RST=1. RST during a multiply aborts it; no result is produced.
- IN_READY = !RST && !mul_busy && (!OUT_VALID || OUT_READY). It is combinational and does not depend on IN_VALID.
- Accept = IN_VALID && IN_READY.
- Single-cycle units: on the accept edge, OUT_R, OUT_FLAGS and OUT_VALID=1 are written. Latency is 1 cycle.
- OUT_VALID clears on an edge with OUT_READY=1 and no new accept. OUT_R and OUT_FLAGS stay stable while OUT_VALID=1 && OUT_READY=0.
- Back-to-back: an op accepted on the edge after a result registers sees the updated CF.
- Arith unit:
  - op0 ADD: A+B.
  - op1 SUB: A-B.
  - op2 ADC: A+B+CF.
  - op3 SBB: A-B-CF.
  - CF is carry-out for add and borrow for sub (CF=1 iff unsigned A < B + borrow_in).
  - OF is two's-complement signed overflow.
- Logic unit: op0 ~A, op1 A&B, op2 A|B, op3 A^B. CF=0, OF=0.
- Lshift unit, fill of vacated LSBs: op0 zeros, op1 ones, op2 zeros, op3 rotate.
- Rshift unit, fill of vacated MSBs: op0 zeros, op1 ones, op2 copies of A[msb] (arithmetic), op3 rotate.
- Shift flags:
  - Shift amount 0: R=A.
  - CF = last bit shifted out; if the amount is 0, CF is unchanged.
  - OF=0.
- Mul unit (unsigned, shift-add, one partial product per cycle):
  - States: IDLE -> BUSY (bit_width cycles) -> IDLE.
  - Accepted at edge k: mul_busy=1 from k, result/flags/OUT_VALID written at edge k+bit_width.
  - op0 returns the low half: CF=OF=1 iff high half != 0.
  - op1 returns the high half: CF=OF=0.
  - op2/op3 behave as op0.
- SF = R[msb] and ZF = (R==0) for every legal unit.
- Illegal units 5-7: 1-cycle, R=0, OUT_FLAGS unchanged, OUT_VALID=1.
- Inputs are only sampled on the accept edge. Operand changes while busy are ignored.

Optional Feature:
- ALU_MUL_EN defined: mul unit present as above.
- ALU_MUL_EN undefined: no multiplier logic. IN_UNIT=4 is treated as illegal (1-cycle, R=0, flags unchanged), and mul_busy is tied to 0.

Test Plan (bit_width=8):
- ADD A=0xFF B=0x01 -> R=0x00, flags {SF0 ZF1 OF0 CF1}; then ADC A=0x00 B=0x00 -> R=0x01, CF=0.
- SUB A=0x80 B=0x01 -> R=0x7F, OF=1, CF=0, SF=0; SUB A=0x01 B=0x02 -> R=0xFF, CF=1, SF=1.
- Rshift op2 A=0x90 B=3 -> R=0xF2, CF=0. Lshift op3 A=0x81 B=1 -> R=0x03, CF=1. Rshift op1 A=0x00 B=2 -> R=0xC0.
- Multiply, ALU_MUL_EN: MUL op0 A=0x10 B=0x20 -> IN_READY=0 for 8 cycles, OUT_VALID at accept+8, R=0x00, CF=OF=1, ZF=1. Then op1 with the same operands -> R=0x02.
- Backpressure: OUT_READY=0 for 3 cycles with IN_VALID=1 and a logic op pending -> IN_READY=0, OUT_R stable. When OUT_READY=1, the pending op is accepted that cycle and the result follows 1 cycle later; no op is lost or duplicated.
- Reset mid-multiply: RST for 1 cycle at busy cycle 4 -> next cycle OUT_VALID=0, OUT_FLAGS=0, IN_READY=1. A new ADD 0x02+0x03 accepted then gives R=0x05.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and data bundle between operand fetch, the alu_seq ALU and writeback.
interface alu_seq_if #(parameter int bit_width = 8);
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [2:0]           IN_UNIT;
    logic [1:0]           IN_OP;
    logic [bit_width-1:0] IN_A;
    logic [bit_width-1:0] IN_B;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [bit_width-1:0] OUT_R;
    logic [3:0]           OUT_FLAGS;

    modport master (
        output IN_VALID, IN_UNIT, IN_OP, IN_A, IN_B, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_R, OUT_FLAGS
    );

    modport slave (
        input  IN_VALID, IN_UNIT, IN_OP, IN_A, IN_B, OUT_READY,
        output IN_READY, OUT_VALID, OUT_R, OUT_FLAGS
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with internal {SF,ZF,OF,CF} flag register.
// Define ALU_MUL_EN to include the iterative shift-add multiplier (unit 4).
module alu_seq #(
    parameter int bit_width = 8
) (
    input  logic     CLK,
    input  logic     RST,
    alu_seq_if.slave bus
);
    localparam int W  = bit_width;
    localparam int SW = $clog2(bit_width);

    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    unit;
    logic [1:0]    op;
    logic [SW-1:0] amt;

    logic [W-1:0]  r_q;
    logic [3:0]    flags_q;
    logic          valid_q;
    logic          ready;
    logic          accept;
    logic          is_mul;
    logic          mul_busy;
    logic          mul_done;
    logic [W-1:0]  mul_r;
    logic [3:0]    mul_flags;

    logic [W-1:0]  sc_r;
    logic [3:0]    sc_flags;
    logic [W:0]    sum;
    logic [2*W:0]  u_l;
    logic [2*W:0]  u_r;
    logic [W-1:0]  fill;
    logic          cin;
    logic          cf;
    logic          of;
    logic          legal;

    assign a    = bus.IN_A;
    assign b    = bus.IN_B;
    assign unit = bus.IN_UNIT;
    assign op   = bus.IN_OP;
    assign amt  = b[SW-1:0];

    assign ready         = !RST && !mul_busy && (!valid_q || bus.OUT_READY);
    assign accept        = bus.IN_VALID && ready;
    assign bus.IN_READY  = ready;
    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_R     = r_q;
    assign bus.OUT_FLAGS = flags_q;

    always_comb begin
        sc_r  = '0;
        cf    = flags_q[0];
        of    = flags_q[1];
        sum   = '0;
        u_l   = '0;
        u_r   = '0;
        fill  = '0;
        cin   = 1'b0;
        legal = 1'b1;
        case (unit)
            3'd0: begin
                cin = op[1] & flags_q[0];
                if (!op[0]) begin
                    sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    sc_r = sum[W-1:0];
                    of   = (a[W-1] == b[W-1]) && (sc_r[W-1] != a[W-1]);
                end else begin
                    // bit W of the widened difference is the borrow
                    sum  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                    sc_r = sum[W-1:0];
                    of   = (a[W-1] != b[W-1]) && (sc_r[W-1] != a[W-1]);
                end
                cf = sum[W];
            end
            3'd1: begin
                case (op)
                    2'd0:    sc_r = ~a;
                    2'd1:    sc_r = a & b;
                    2'd2:    sc_r = a | b;
                    default: sc_r = a ^ b;
                endcase
                cf = 1'b0;
                of = 1'b0;
            end
            3'd2: begin
                case (op)
                    2'd1:    fill = '1;
                    2'd3:    fill = a;
                    default: fill = '0;
                endcase
                // guard bit above A catches the last bit shifted out
                u_l  = {1'b0, a, fill} << amt;
                sc_r = u_l[2*W-1:W];
                cf   = (amt == '0) ? flags_q[0] : u_l[2*W];
                of   = 1'b0;
            end
            3'd3: begin
                case (op)
                    2'd0:    fill = '0;
                    2'd1:    fill = '1;
                    2'd2:    fill = {W{a[W-1]}};
                    default: fill = a;
                endcase
                u_r  = {fill, a, 1'b0} >> amt;
                sc_r = u_r[W:1];
                cf   = (amt == '0) ? flags_q[0] : u_r[0];
                of   = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        sc_flags = legal ? {sc_r[W-1], (sc_r == '0), of, cf} : flags_q;
    end

`ifdef ALU_MUL_EN
    typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

    mul_state_t     state;
    mul_state_t     state_next;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier;
    logic [SW-1:0]  cnt;
    logic           mop_hi;
    logic           mul_cf;

    assign is_mul   = (unit == 3'd4);
    assign mul_busy = (state == MUL_BUSY);

    always_comb begin
        state_next = state;
        mul_done   = 1'b0;
        acc_next   = acc + (mplier[0] ? mcand : '0);
        case (state)
            MUL_IDLE: if (accept && is_mul) state_next = MUL_BUSY;
            MUL_BUSY: begin
                if (cnt == SW'(W - 1)) begin
                    state_next = MUL_IDLE;
                    mul_done   = 1'b1;
                end
            end
            default: state_next = MUL_IDLE;
        endcase
        mul_r     = mop_hi ? acc_next[2*W-1:W] : acc_next[W-1:0];
        mul_cf    = mop_hi ? 1'b0 : (acc_next[2*W-1:W] != '0);
        mul_flags = {mul_r[W-1], (mul_r == '0), mul_cf, mul_cf};
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= MUL_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (accept && is_mul) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            mop_hi <= (op == 2'd1);
        end else if (state == MUL_BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign is_mul    = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_r     = '0;
    assign mul_flags = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else if (mul_done) begin
            r_q     <= mul_r;
            flags_q <= mul_flags;
            valid_q <= 1'b1;
        end else if (accept && !is_mul) begin
            r_q     <= sc_r;
            flags_q <= sc_flags;
            valid_q <= 1'b1;
        end else if (bus.OUT_READY) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at bit_width=8.
// Multiplier steps are compiled in only when ALU_MUL_EN is defined.
module tb_alu_seq;
    logic CLK;
    logic RST;
    int   tests;
    int   failures;

    alu_seq_if #(.bit_width(8)) bus ();

    alu_seq #(.bit_width(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] u, input logic [1:0] o,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        bus.IN_UNIT   = u;
        bus.IN_OP     = o;
        bus.IN_A      = a;
        bus.IN_B      = b;
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = 1'b1;
        check({tag, " in_ready"}, 16'(bus.IN_READY), 16'h1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] r, input logic [3:0] f);
        check({tag, " out_valid"}, 16'(bus.OUT_VALID), 16'h1);
        check({tag, " out_r"},     16'(bus.OUT_R),     16'(r));
        check({tag, " out_flags"}, 16'(bus.OUT_FLAGS), 16'(f));
    endtask

    initial begin
        tests         = 0;
        failures      = 0;
        RST           = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.IN_UNIT   = 3'd0;
        bus.IN_OP     = 2'd0;
        bus.IN_A      = 8'h00;
        bus.IN_B      = 8'h00;
        bus.OUT_READY = 1'b1;

        repeat (2) @(negedge CLK);
        check("rst in_ready",  16'(bus.IN_READY),  16'h0);
        check("rst out_valid", 16'(bus.OUT_VALID), 16'h0);
        check("rst out_r",     16'(bus.OUT_R),     16'h0);
        check("rst out_flags", 16'(bus.OUT_FLAGS), 16'h0);
        RST = 1'b0;
        #1;
        check("post-rst in_ready", 16'(bus.IN_READY), 16'h1);

        // flags are {SF,ZF,OF,CF}
        do_op("add ff+01", 3'd0, 2'd0, 8'hFF, 8'h01); expect_res("add ff+01", 8'h00, 4'b0101);
        do_op("adc 00+00", 3'd0, 2'd2, 8'h00, 8'h00); expect_res("adc 00+00", 8'h01, 4'b0000);
        do_op("sub 80-01", 3'd0, 2'd1, 8'h80, 8'h01); expect_res("sub 80-01", 8'h7F, 4'b0010);
        do_op("sub 01-02", 3'd0, 2'd1, 8'h01, 8'h02); expect_res("sub 01-02", 8'hFF, 4'b1001);
        do_op("sbb 05-02", 3'd0, 2'd3, 8'h05, 8'h02); expect_res("sbb 05-02", 8'h02, 4'b0000);
        do_op("add 7f+01", 3'd0, 2'd0, 8'h7F, 8'h01); expect_res("add 7f+01", 8'h80, 4'b1010);
        do_op("illegal 6", 3'd6, 2'd0, 8'h12, 8'h34); expect_res("illegal 6", 8'h00, 4'b1010);
`ifndef ALU_MUL_EN
        do_op("unit4 illegal", 3'd4, 2'd0, 8'h10, 8'h20); expect_res("unit4 illegal", 8'h00, 4'b1010);
`endif
        do_op("and", 3'd1, 2'd1, 8'hF0, 8'h3C); expect_res("and", 8'h30, 4'b0000);
        do_op("xor", 3'd1, 2'd3, 8'hAA, 8'hAA); expect_res("xor", 8'h00, 4'b0100);
        do_op("not", 3'd1, 2'd0, 8'h0F, 8'h00); expect_res("not", 8'hF0, 4'b1000);

        do_op("rsh arith", 3'd3, 2'd2, 8'h90, 8'h03); expect_res("rsh arith", 8'hF2, 4'b1000);
        do_op("lsh rot",   3'd2, 2'd3, 8'h81, 8'h01); expect_res("lsh rot",   8'h03, 4'b0001);
        do_op("lsh amt0",  3'd2, 2'd0, 8'h5A, 8'h08); expect_res("lsh amt0",  8'h5A, 4'b0001);
        do_op("rsh ones",  3'd3, 2'd1, 8'h00, 8'h02); expect_res("rsh ones",  8'hC0, 4'b1000);
        do_op("lsh ones",  3'd2, 2'd1, 8'h01, 8'h07); expect_res("lsh ones",  8'hFF, 4'b1000);
        do_op("rsh zeros", 3'd3, 2'd0, 8'h81, 8'h01); expect_res("rsh zeros", 8'h40, 4'b0001);
        do_op("rsh rot",   3'd3, 2'd3, 8'h01, 8'h01); expect_res("rsh rot",   8'h80, 4'b1001);

`ifdef ALU_MUL_EN
        do_op("mul lo", 3'd4, 2'd0, 8'h10, 8'h20);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("mul lo busy in_ready",  16'(bus.IN_READY),  16'h0);
            check("mul lo busy out_valid", 16'(bus.OUT_VALID), 16'h0);
        end
        @(posedge CLK);
        #1;
        expect_res("mul lo", 8'h00, 4'b0111);
        do_op("mul hi", 3'd4, 2'd1, 8'h10, 8'h20);
        repeat (8) @(posedge CLK);
        #1;
        expect_res("mul hi", 8'h02, 4'b0000);
`endif

        // backpressure: result held while a logic op waits
        do_op("bp first", 3'd1, 2'd1, 8'hF0, 8'h3C); expect_res("bp first", 8'h30, 4'b0000);
        bus.OUT_READY = 1'b0;
        bus.IN_UNIT   = 3'd1;
        bus.IN_OP     = 2'd2;
        bus.IN_A      = 8'h0F;
        bus.IN_B      = 8'h50;
        bus.IN_VALID  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp stall in_ready",  16'(bus.IN_READY),  16'h0);
            check("bp stall out_valid", 16'(bus.OUT_VALID), 16'h1);
            check("bp stall out_r",     16'(bus.OUT_R),     16'h30);
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        bus.OUT_READY = 1'b1;
        #1;
        check("bp release in_ready", 16'(bus.IN_READY), 16'h1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        expect_res("bp second", 8'h5F, 4'b0000);
        @(posedge CLK);
        #1;
        check("bp no dup out_valid", 16'(bus.OUT_VALID), 16'h0);

`ifdef ALU_MUL_EN
        do_op("rst mul", 3'd4, 2'd0, 8'h0F, 8'h0F);
        repeat (3) @(posedge CLK);
`else
        do_op("rst pre", 3'd0, 2'd1, 8'h01, 8'h02);
`endif
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("rst mid out_valid", 16'(bus.OUT_VALID), 16'h0);
        check("rst mid out_flags", 16'(bus.OUT_FLAGS), 16'h0);
        check("rst mid in_ready",  16'(bus.IN_READY),  16'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("rst aborted out_valid", 16'(bus.OUT_VALID), 16'h0);
        end
        do_op("add 02+03", 3'd0, 2'd0, 8'h02, 8'h03); expect_res("add 02+03", 8'h05, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
